// File: rtl/cla_pkg.sv
// Shared definitions for the 6-bit CLA limb sequencer: limb width,
// default CLA latency and the controller state encoding.
package cla_pkg;

  localparam int LIMB_W      = 6;
  localparam int ADD_LAT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla6_limb_sequencer.sv
// Multi-precision add controller wrapped around the registered 6-bit CLA.
// A wide operand pair is accepted over valid/ready, issued to the CLA one
// limb at a time (LSB limb first) with the carry chained between limbs,
// and the assembled result is returned over valid/ready.
// Optional feature macro: CLA_SUB_EN adds the req_sub port (A - B).
module cla6_limb_sequencer
  import cla_pkg::*;
#(
  parameter int LIMBS   = 3,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic                      CLK,
  input  logic                      CLR_,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [LIMB_W*LIMBS-1:0]   req_a,
  input  logic [LIMB_W*LIMBS-1:0]   req_b,
  input  logic                      req_cin,
`ifdef CLA_SUB_EN
  input  logic                      req_sub,
`endif
  output logic [LIMB_W-1:0]         add_a,
  output logic [LIMB_W-1:0]         add_b,
  output logic                      add_cin,
  input  logic [LIMB_W-1:0]         add_sum,
  input  logic                      add_cout,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [LIMB_W*LIMBS-1:0]   rsp_sum,
  output logic                      rsp_cout,
  output logic                      rsp_ovf
);

  localparam int W     = LIMB_W * LIMBS;
  localparam int CNT_W = $clog2(ADD_LAT + 2);
  localparam int K_W   = $clog2(LIMBS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(LIMBS - 1);

  state_t              state_r, state_next_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [K_W-1:0]      k_r;
  logic [K_W-1:0]      k_inc_s;
  logic [W-1:0]        a_r, b_r, acc_r;
  logic [W-1:0]        acc_next_s;
  logic [W-1:0]        b_in_s;
  logic [LIMB_W-1:0]   a_limb_s, b_limb_s;
  logic                sub_s, cin0_s;
  logic                accept_s, sample_s, last_s;

`ifdef CLA_SUB_EN
  assign sub_s = req_sub;
`else
  assign sub_s = 1'b0;
`endif

  // Subtraction folds into the add path: invert B once at latch time and force carry-in.
  assign b_in_s = sub_s ? ~req_b : req_b;
  assign cin0_s = sub_s ? 1'b1 : req_cin;
  assign k_inc_s = k_r + 1'b1;

  // Limb select for the next limb to issue, and the accumulator with the current limb merged in.
  always_comb begin
    a_limb_s   = a_r[k_inc_s*LIMB_W +: LIMB_W];
    b_limb_s   = b_r[k_inc_s*LIMB_W +: LIMB_W];
    acc_next_s = acc_r;
    acc_next_s[k_r*LIMB_W +: LIMB_W] = add_sum;
  end

  // Next-state and strobe decode; a limb is sampled when the wait counter has run out.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    sample_s     = 1'b0;
    last_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept_s     = 1'b1;
          state_next_s = WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == {CNT_W{1'b0}}) begin
          sample_s = 1'b1;
          if (k_r == K_LAST) begin
            last_s       = 1'b1;
            state_next_s = DONE;
          end else begin
            state_next_s = WAIT;
          end
        end else begin
          state_next_s = WAIT;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge CLK or negedge CLR_) begin
    if (!CLR_) begin
      state_r   <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      req_ready <= (state_next_s == IDLE);
      rsp_valid <= (state_next_s == DONE);
    end
  end

  // Operand latch, limb issue, wait counter and result capture.
  always_ff @(posedge CLK or negedge CLR_) begin
    if (!CLR_) begin
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      acc_r    <= {W{1'b0}};
      k_r      <= {K_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      add_a    <= {LIMB_W{1'b0}};
      add_b    <= {LIMB_W{1'b0}};
      add_cin  <= 1'b0;
      rsp_sum  <= {W{1'b0}};
      rsp_cout <= 1'b0;
      rsp_ovf  <= 1'b0;
    end else if (accept_s) begin
      a_r     <= req_a;
      b_r     <= b_in_s;
      k_r     <= {K_W{1'b0}};
      cnt_r   <= CNT_LOAD;
      add_a   <= req_a[LIMB_W-1:0];
      add_b   <= b_in_s[LIMB_W-1:0];
      add_cin <= cin0_s;
    end else if (sample_s) begin
      acc_r <= acc_next_s;
      if (last_s) begin
        // Result registers change only here so they hold across the next operation.
        rsp_sum  <= acc_next_s;
        rsp_cout <= add_cout;
        rsp_ovf  <= (a_r[W-1] == b_r[W-1]) && (add_sum[LIMB_W-1] != a_r[W-1]);
      end else begin
        k_r     <= k_inc_s;
        cnt_r   <= CNT_LOAD;
        add_a   <= a_limb_s;
        add_b   <= b_limb_s;
        add_cin <= add_cout;
      end
    end else if (state_r == WAIT) begin
      cnt_r <= cnt_r - 1'b1;
    end
  end

endmodule
